// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and digit byte selection for the scan mux
package sseg_pkg;

    localparam int MAX_DIGITS = 16;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
    localparam logic [7:0]            SEG_BLANK = 8'hFF;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;
    localparam int DP_BIT    = 7;

    // Byte idx of a bus holding up to MAX_DIGITS packed segment bytes
    function automatic logic [7:0] digit_select(input logic [8*MAX_DIGITS-1:0] seg_bus,
                                                input logic [3:0] idx);
        return seg_bus[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mod_m_tick.sv
// rtl/mod_m_tick.sv - modulo-M counter with a single-cycle wrap pulse
module mod_m_tick #(
    parameter int M = 16,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    // Wrap is combinational so the caller can update dependent state on the same edge
    assign wrap = en && (count == W'(M - 1));

    // Count 0..M-1 on each enabled cycle, then return to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - multiplexed seven-segment driver with guard, PWM, enable and blink
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 12500,
    parameter int GUARD_CYCLES = 64,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int SLOT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SLOT_W-1:0]       slot_cnt;
    logic                    slot_wrap;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_wrap;
    logic                    blink_wrap;
    logic                    blink_off;
    logic                    fresh;
    logic [BRIGHT_W-1:0]     bright_q;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic                    guard_done;
    logic                    pwm_on;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              sseg_next;
    logic [8*MAX_DIGITS-1:0] seg_bus;
    logic [3:0]              idx4;

    mod_m_tick #(.M(DIGIT_CYCLES), .W(SLOT_W)) u_slot (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (slot_cnt),
        .wrap  (slot_wrap)
    );

    // A frame ends when the last digit's slot wraps; with one digit that is every slot
    assign frame_wrap = slot_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));

    mod_m_tick #(.M(BLINK_FRAMES), .W(BLINK_W)) u_blink (
        .clk   (clk),
        .reset (reset),
        .en    (frame_wrap),
        .count (),
        .wrap  (blink_wrap)
    );

    // Advance the scanned digit at each slot boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx <= '0;
        end else if (slot_wrap) begin
            digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
        end
    end

    // Blink phase flips every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_off <= 1'b0;
        end else if (blink_wrap) begin
            blink_off <= ~blink_off;
        end
    end

    // Brightness is taken on entry to a frame; the first frame after reset latches
    // in its cycle 0 because no wrap precedes it
    always_ff @(posedge clk) begin
        if (reset) begin
            fresh    <= 1'b1;
            bright_q <= '0;
        end else begin
            fresh <= 1'b0;
            if (frame_wrap || fresh) begin
                bright_q <= brightness;
            end
        end
    end

    // PWM phase restarts each slot and only runs once the guard interval is over
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (slot_wrap) begin
            pwm_cnt <= '0;
        end else if (guard_done) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Decide whether the current digit is lit and what the pins should show
    always_comb begin
        guard_done = (slot_cnt >= SLOT_W'(GUARD_CYCLES));
        pwm_on     = (&bright_q) || (pwm_cnt < bright_q);
        lit        = guard_done && digit_en[digit_idx]
                     && !(blink_en[digit_idx] && blink_off) && pwm_on;
        seg_bus    = (8*MAX_DIGITS)'(seg_in);
        idx4       = 4'(digit_idx);
        an_next    = ANODE_OFF[NUM_DIGITS-1:0];
        sseg_next  = SEG_BLANK;
        if (lit) begin
            an_next   = ~(NUM_DIGITS'(1) << digit_idx);
            sseg_next = ~digit_select(seg_bus, idx4);
        end
    end

    // Register the pins so anode and segment data always change together
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= ANODE_OFF[NUM_DIGITS-1:0];
            sseg       <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            sseg       <= sseg_next;
            frame_tick <= frame_wrap;
        end
    end

endmodule
